// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: game sequencer for the scrolling dino/ground display.
// Owns the IDLE/RUN/OVER state machine, the frame tick, the jump physics, the
// ground scroll and the score. The renderer reads dino_y/ground_x and returns hit.
//
// Build option: define DINO_SPEEDUP_EN to shorten the tick period as the score
// climbs (five speed levels). Without it the tick period is fixed at TICK_DIV.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE(0) | waiting for a start press, outputs at reset values
// RUN (1) | game running, updates on every frame_tick
// OVER(2) | collision seen, everything frozen until a start press

module dino_game_ctrl #(
    parameter int TICK_DIV      = 20000000,
    parameter int X_MAX         = 96,
    parameter int GROUND_LEN    = 65,
    parameter int DINO_GROUND_Y = 35,
    parameter int JUMP_V        = 5,
    parameter int GRAVITY       = 1,
    parameter int SCORE_MAX     = 9999
`ifdef DINO_SPEEDUP_EN
    , parameter int SPEEDUP_STEP = 100
`endif
) (
    input  logic        sys_clk,
    input  logic        btnC,
    input  logic        start,
    input  logic        jump,
    input  logic        hit,
    output logic [1:0]  state,
    output logic        frame_tick,
    output logic [5:0]  dino_y,
    output logic        airborne,
    output logic [6:0]  ground_x,
    output logic [13:0] score
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [5:0]        Y_GND     = 6'(DINO_GROUND_Y);
    localparam logic [5:0]        Y_TAKEOFF = 6'(DINO_GROUND_Y - JUMP_V);
    localparam logic signed [7:0] V_JUMP    = 8'(JUMP_V);
    localparam logic signed [7:0] V_GRAV    = 8'(GRAVITY);
    // ground_x is a 7-bit two's-complement value; -GROUND_LEN and X_MAX-1 are
    // taken modulo 128, which keeps the wrap compare exact at this width.
    localparam logic [6:0]        GX_WRAP   = 7'(-GROUND_LEN);
    localparam logic [6:0]        GX_RELOAD = 7'(X_MAX - 1);
    localparam logic [13:0]       SCORE_SAT = 14'(SCORE_MAX);

    logic                  start_q, jump_q;
    logic                  start_rise, jump_rise;
    logic [CNT_W-1:0]      tick_cnt;
    logic [CNT_W-1:0]      tick_last;
    logic signed [7:0]     velocity;
    logic                  jump_pend;
    logic signed [7:0]     v_next, y_next;
    logic                  lands;

    assign start_rise = start & ~start_q;
    assign jump_rise  = jump  & ~jump_q;
    assign frame_tick = (state == ST_RUN) && (tick_cnt == tick_last);

    // Previous-cycle button samples. Reset loads them as "held" so a button
    // already down when reset releases needs a fresh press to register.
    always_ff @(posedge sys_clk) begin
        if (btnC) begin
            start_q <= 1'b1;
            jump_q  <= 1'b1;
        end else begin
            start_q <= start;
            jump_q  <= jump;
        end
    end

    // Jump physics step: gravity is applied before the position step, so the
    // first airborne tick after takeoff moves by JUMP_V-GRAVITY.
    always_comb begin
        v_next = velocity - V_GRAV;
        y_next = $signed({2'b00, dino_y}) - v_next;
        lands  = (y_next >= $signed({2'b00, Y_GND}));
    end

    // Game-state FSM, tick counter and all per-tick game updates.
    always_ff @(posedge sys_clk) begin
        if (btnC) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            dino_y    <= Y_GND;
            airborne  <= 1'b0;
            velocity  <= '0;
            jump_pend <= 1'b0;
            ground_x  <= '0;
            score     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    if (start_rise) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (hit) state <= ST_OVER;
                    tick_cnt <= frame_tick ? '0 : tick_cnt + 1'b1;

                    if (frame_tick && !airborne && jump_pend)
                        jump_pend <= 1'b0;
                    else if (jump_rise && !airborne)
                        jump_pend <= 1'b1;

                    if (frame_tick) begin
                        if (!airborne) begin
                            if (jump_pend) begin
                                velocity <= V_JUMP;
                                airborne <= 1'b1;
                                dino_y   <= Y_TAKEOFF;
                            end
                        end else if (lands) begin
                            dino_y   <= Y_GND;
                            airborne <= 1'b0;
                            velocity <= '0;
                        end else begin
                            dino_y   <= y_next[5:0];
                            velocity <= v_next;
                        end

                        ground_x <= (ground_x == GX_WRAP) ? GX_RELOAD : ground_x - 1'b1;

                        if (score != SCORE_SAT) score <= score + 1'b1;
                    end
                end
                ST_OVER: begin
                    if (start_rise) begin
                        state     <= ST_RUN;
                        tick_cnt  <= '0;
                        dino_y    <= Y_GND;
                        airborne  <= 1'b0;
                        velocity  <= '0;
                        jump_pend <= 1'b0;
                        ground_x  <= '0;
                        score     <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DINO_SPEEDUP_EN
    localparam int STEP_W = (SPEEDUP_STEP > 1) ? $clog2(SPEEDUP_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(SPEEDUP_STEP - 1);
    localparam logic [CNT_W-1:0]  PERIOD_DEC = CNT_W'(TICK_DIV / 8);

    logic [2:0]        level;
    logic [STEP_W-1:0] step_cnt;

    // Speed level tracks every SPEEDUP_STEP score increments; each level trims
    // TICK_DIV/8 from the tick period by stepping the terminal count down.
    always_ff @(posedge sys_clk) begin
        if (btnC || (state == ST_OVER && start_rise)) begin
            level     <= '0;
            step_cnt  <= '0;
            tick_last <= TC_LAST;
        end else if (frame_tick && score != SCORE_SAT) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (level < 3'd4) begin
                    level     <= level + 1'b1;
                    tick_last <= tick_last - PERIOD_DEC;
                end
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end
`else
    assign tick_last = TC_LAST;
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed testbench for dino_game_ctrl with TICK_DIV=4.
module tb_dino_game_ctrl;

    logic        sys_clk;
    logic        btnC, start, jump, hit;
    logic [1:0]  state;
    logic        frame_tick;
    logic [5:0]  dino_y;
    logic        airborne;
    logic [6:0]  ground_x;
    logic [13:0] score;

    int n_assert = 0;
    int n_fail   = 0;

    dino_game_ctrl #(.TICK_DIV(4)) dut (
        .sys_clk   (sys_clk),
        .btnC      (btnC),
        .start     (start),
        .jump      (jump),
        .hit       (hit),
        .state     (state),
        .frame_tick(frame_tick),
        .dino_y    (dino_y),
        .airborne  (airborne),
        .ground_x  (ground_x),
        .score     (score)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // advance n rising edges, land 1 time unit after the last one
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // wait for the next frame_tick (bounded), then step past it so its updates are visible
    task automatic next_tick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 12) begin
            cyc(1);
            n++;
        end
        chk("tick_seen", {31'd0, frame_tick}, 32'd1);
        cyc(1);
    endtask

    task automatic pulse_jump();
        jump = 1'b1;
        cyc(1);
        jump = 1'b0;
    endtask

    initial begin
        int exp_y[11];
        exp_y = '{30, 26, 23, 21, 20, 20, 21, 23, 26, 30, 35};
        btnC = 1'b1; start = 1'b0; jump = 1'b0; hit = 1'b0;
        cyc(2);
        btnC = 1'b0;
        cyc(1);
        chk("rst_state", state, 0);
        chk("rst_dino_y", dino_y, 35);
        chk("rst_airborne", airborne, 0);
        chk("rst_ground_x", ground_x, 0);
        chk("rst_score", score, 0);
        chk("rst_tick", frame_tick, 0);

        // start press -> RUN one cycle later; tick every 4 cycles
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("start_run", state, 1);
        chk("tick_cnt0", frame_tick, 0);
        cyc(3);
        chk("tick_first", frame_tick, 1);
        cyc(1);
        chk("tick_gap", frame_tick, 0);
        chk("score_1", score, 1);
        cyc(3);
        chk("tick_second", frame_tick, 1);
        next_tick();
        next_tick();
        chk("score_3", score, 3);
        chk("gx_m3", ground_x, 125);   // -3 in 7 bits

        // single jump trajectory
        pulse_jump();
        for (int i = 0; i < 11; i++) begin
            next_tick();
            chk("jump1_y", dino_y, exp_y[i]);
            chk("jump1_air", airborne, (i < 10) ? 1 : 0);
        end

        // second press at the peak is ignored
        pulse_jump();
        for (int i = 0; i < 5; i++) begin
            next_tick();
            chk("jump2_y", dino_y, exp_y[i]);
        end
        pulse_jump();
        for (int i = 5; i < 11; i++) begin
            next_tick();
            chk("jump2_y", dino_y, exp_y[i]);
            chk("jump2_air", airborne, (i < 10) ? 1 : 0);
        end
        next_tick();
        chk("no_rejump_y", dino_y, 35);
        chk("no_rejump_air", airborne, 0);
        chk("score_26", score, 26);

        // collision mid-jump at dino_y=23
        pulse_jump();
        next_tick();
        next_tick();
        next_tick();
        chk("hit_pre_y", dino_y, 23);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("over_state", state, 2);
        pulse_jump();
        cyc(19);
        chk("over_hold_state", state, 2);
        chk("over_hold_y", dino_y, 23);
        chk("over_hold_score", score, 29);
        chk("over_hold_gx", ground_x, 99);   // -29 in 7 bits
        chk("over_no_tick", frame_tick, 0);

        // restart from OVER
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_y", dino_y, 35);
        chk("restart_air", airborne, 0);
        chk("restart_score", score, 0);
        chk("restart_gx", ground_x, 0);

        // ground wrap
        for (int i = 0; i < 65; i++) next_tick();
        chk("gx_m65", ground_x, 63);   // -65 in 7 bits
        next_tick();
        chk("gx_wrap", ground_x, 95);
        next_tick();
        chk("gx_94", ground_x, 94);
        chk("score_67", score, 67);

        // score saturation
        for (int i = 0; i < 9940; i++) next_tick();
        chk("score_sat", score, 9999);

        // reset mid-jump
        pulse_jump();
        next_tick();
        next_tick();
        chk("pre_rst_y", dino_y, 26);
        btnC = 1'b1;
        cyc(1);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_y", dino_y, 35);
        chk("mid_rst_air", airborne, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_gx", ground_x, 0);

        // start held through reset release does not start the game
        start = 1'b1;
        cyc(1);
        btnC = 1'b0;
        cyc(3);
        chk("held_start_idle", state, 0);
        start = 1'b0;
        cyc(1);
        chk("release_idle", state, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("fresh_start_run", state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
